fifo_syn_param: RTL and testbench
=================================

FIFO_SYN_PARAM -- requirements
Module: fifo_syn_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage words; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, usedw level at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, usedw level at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0, output mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have: clr  in  1  synchronous clear of contents and status.
REQ-009 SHALL have: wr  in  1  write request; data  in  WIDTH  write word.
REQ-010 SHALL have: rd  in  1  read request / pop.
REQ-011 SHALL have: q  out  WIDTH  read data.
REQ-012 SHALL have: full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-013 SHALL have: usedw  out  AW+1 (AW = log2 DEPTH)  stored word count, 0..DEPTH inclusive.
REQ-014 SHALL have: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-015 SHALL keep wr/rd pointers of AW+1 bits; empty = pointers equal; full = low AW bits equal, MSBs differ; no hard-coded bit indices.
REQ-016 SHALL accept a write (wr_acc) iff wr=1 and full=0; accepted word stored at write pointer, pointer increments modulo 2*DEPTH.
REQ-017 SHALL accept a read (rd_acc) iff rd=1 and empty=0; read pointer increments modulo 2*DEPTH.
REQ-018 SHALL reject wr while full even if rd is accepted same cycle; rd while empty rejected even if wr accepted same cycle.
REQ-019 SHALL update usedw each cycle by +1 (wr_acc only), -1 (rd_acc only), unchanged (both or neither); usedw always equals pointer difference.
REQ-020 SHALL drive almost_full = (usedw >= AF_LEVEL), almost_empty = (usedw <= AE_LEVEL), combinationally from registered usedw.
REQ-021 FWFT=0: q SHALL load the head word on the clock edge of rd_acc (valid from next cycle) and hold otherwise.
REQ-022 FWFT=1: q SHALL present the head word whenever empty=0, with no rd needed; rd_acc advances q to the next word next cycle; q holds last value while empty.
REQ-023 FWFT=1: a write into an empty FIFO SHALL deassert empty and present the word on q in the cycle after the write edge.
REQ-024 SHALL set overflow on the edge where wr=1 and full=1, underflow where rd=1 and empty=1; both stay set until clr or reset; rejected data discarded, state unchanged.
REQ-025 clr=1 SHALL on the next edge zero pointers, usedw, q, overflow, underflow, overriding wr/rd that cycle; memory contents need not be cleared.
REQ-026 SHALL have zero write-to-flag latency beyond one edge: full, empty, usedw reflect all accepts by the following cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously force pointers=0, usedw=0, q=0, overflow=0, underflow=0, giving empty=1, full=0, almost_empty=1, almost_full=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; first accepted write after release lands at address 0.

Structure
REQ-029 Shared package/include fifo_pkg SHALL hold the clog2 function and the FWFT mode constants.
REQ-030 Storage SHALL be sub-module fifo_ram (simple dual-port, one write port, one synchronous/async read port, parameters WIDTH, DEPTH); no reset on the array.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-031 Fill: 8 writes 0x01..0x08 -> usedw 8, full=1, almost_full=1 from usedw 6; 9th write 0xFF -> overflow=1, usedw stays 8.
REQ-032 Drain FWFT=0: 8 reads -> q = 0x01..0x08 each one cycle after rd; 9th read -> underflow=1, q holds 0x08, empty=1.
REQ-033 Simultaneous: at usedw=4, wr+rd for 10 cycles -> usedw stays 4, order preserved across pointer wrap.
REQ-034 FWFT=1: one write 0xA5 into empty -> next cycle empty=0, q=0xA5 with rd=0; rd -> empty=1, usedw 0.
REQ-035 Full+rd+wr: at full, wr=1 rd=1 -> read accepted, write rejected, overflow=1, usedw 7.
REQ-036 clr and rst_n: clr at usedw 5 with wr=1 -> usedw 0, flags cleared; rst_n pulse mid-fill -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: output-mode constants and a
// constant-foldable ceil(log2) used to size pointers and addresses.
package fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one synchronous write port and one
// asynchronous read port. The array is intentionally not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/fifo_syn_param.sv
// Parameterised synchronous FIFO with registered-read or first-word-fall-through
// output, occupancy count, almost flags and sticky overflow/underflow.
module fifo_syn_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = FWFT_OFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        data,
    input  logic                    rd,
    output logic [WIDTH-1:0]        q,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   usedw,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    usedw_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_we;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] q_nxt;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign almost_full  = (32'(usedw) >= AF_LEVEL);
    assign almost_empty = (32'(usedw) <= AE_LEVEL);

    assign ram_we = wr_acc && !clr;

    always_comb begin
        wr_acc     = wr && !full;
        rd_acc     = rd && !empty;
        wr_ptr_nxt = wr_acc ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_nxt = rd_acc ? rd_ptr + PW'(1) : rd_ptr;

        usedw_nxt = usedw;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw + PW'(1);
            2'b01:   usedw_nxt = usedw - PW'(1);
            default: usedw_nxt = usedw;
        endcase

        // FWFT looks one pop ahead so q already holds the next head after the edge.
        rd_addr = (FWFT == FWFT_ON) ? rd_ptr_nxt[AW-1:0] : rd_ptr[AW-1:0];

        q_nxt = q;
        if (FWFT == FWFT_ON) begin
            if (usedw_nxt != '0) begin
                // The new head may be the word being written this very cycle.
                if (wr_acc && (rd_ptr_nxt == wr_ptr)) begin
                    q_nxt = data;
                end else begin
                    q_nxt = rd_data;
                end
            end
        end else if (rd_acc) begin
            q_nxt = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            q         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            q         <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            usedw     <= usedw_nxt;
            q         <= q_nxt;
            overflow  <= overflow  || (wr && full);
            underflow <= underflow || (rd && empty);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_data   (data),
        .rd_addr   (rd_addr),
        .rd_data_c (rd_data)
    );

endmodule

// File: tb/tb_fifo_syn_param.sv
// Directed bench: one registered-read and one FWFT instance share stimulus,
// each scenario task checks against hand-computed values.
module tb_fifo_syn_param;
    import fifo_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr   = 1'b0;
    logic       wr    = 1'b0;
    logic       rd    = 1'b0;
    logic [7:0] data  = 8'h00;

    logic [7:0] q0, q1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] usedw0, usedw1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fifo_syn_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(FWFT_OFF)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data(data), .rd(rd), .q(q0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .usedw(usedw0), .overflow(ovf0), .underflow(udf0)
    );

    fifo_syn_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(FWFT_ON)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data(data), .rd(rd), .q(q1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .usedw(usedw1), .overflow(ovf1), .underflow(udf1)
    );

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        wr = w; rd = r; clr = c; data = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({empty0, full0, ae0, af0, ovf0, udf0} !== 6'b101000) $display("FAIL reset_flags0 got %b exp 101000", {empty0, full0, ae0, af0, ovf0, udf0});
        else pass_cnt++;
        total_cnt++;
        if (usedw0 !== 4'd0 || q0 !== 8'h00) $display("FAIL reset_usedw_q0 got usedw=%0d q=%h exp 0 00", usedw0, q0);
        else pass_cnt++;
        total_cnt++;
        if ({empty1, full1, ae1, af1, ovf1, udf1} !== 6'b101000 || q1 !== 8'h00) $display("FAIL reset_u1 got %b q=%h exp 101000 q=00", {empty1, full1, ae1, af1, ovf1, udf1}, q1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(i + 1));
            total_cnt++;
            if (usedw0 !== 4'(i + 1) || af0 !== (i + 1 >= 6) || full0 !== (i == 7))
                $display("FAIL fill[%0d] got usedw=%0d af=%b full=%b exp usedw=%0d af=%b full=%b", i, usedw0, af0, full0, i + 1, (i + 1 >= 6), (i == 7));
            else pass_cnt++;
        end
        total_cnt++;
        if (q1 !== 8'h01 || empty1 !== 1'b0) $display("FAIL fill_fwft_head got q=%h empty=%b exp 01 0", q1, empty1);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        total_cnt++;
        if (ovf0 !== 1'b1 || usedw0 !== 4'd8 || full0 !== 1'b1) $display("FAIL fill_overflow got ovf=%b usedw=%0d full=%b exp 1 8 1", ovf0, usedw0, full0);
        else pass_cnt++;
    endtask

    task automatic test_drain();
        logic [7:0] exp_q1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            exp_q1 = (i < 7) ? 8'(i + 2) : 8'h08;
            total_cnt++;
            if (q0 !== 8'(i + 1) || usedw0 !== 4'(7 - i) || ae0 !== (7 - i <= 2))
                $display("FAIL drain[%0d] got q=%h usedw=%0d ae=%b exp q=%h usedw=%0d ae=%b", i, q0, usedw0, ae0, 8'(i + 1), 7 - i, (7 - i <= 2));
            else pass_cnt++;
            total_cnt++;
            if (q1 !== exp_q1) $display("FAIL drain_fwft[%0d] got q=%h exp %h", i, q1, exp_q1);
            else pass_cnt++;
        end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++;
        if (udf0 !== 1'b1 || q0 !== 8'h08 || empty0 !== 1'b1 || ovf0 !== 1'b1)
            $display("FAIL drain_underflow got udf=%b q=%h empty=%b ovf=%b exp 1 08 1 1", udf0, q0, empty0, ovf0);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        total_cnt++;
        if ({ovf0, udf0, ovf1, udf1} !== 4'b0000 || q0 !== 8'h00 || q1 !== 8'h00 || usedw0 !== 4'd0)
            $display("FAIL drain_clr got flags=%b q0=%h q1=%h usedw=%0d exp 0000 00 00 0", {ovf0, udf0, ovf1, udf1}, q0, q1, usedw0);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] stream [14];
        for (int k = 0; k < 14; k++) stream[k] = (k < 4) ? 8'(8'h10 + k) : 8'(8'h20 + k - 4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, stream[i]);
        total_cnt++;
        if (usedw0 !== 4'd4 || q1 !== 8'h10) $display("FAIL simul_pre got usedw=%0d q1=%h exp 4 10", usedw0, q1);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, stream[i + 4]);
            total_cnt++;
            if (usedw0 !== 4'd4 || q0 !== stream[i] || q1 !== stream[i + 1])
                $display("FAIL simul[%0d] got usedw=%0d q0=%h q1=%h exp 4 %h %h", i, usedw0, q0, q1, stream[i], stream[i + 1]);
            else pass_cnt++;
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_full_rdwr();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        total_cnt++;
        if (usedw0 !== 4'd7 || ovf0 !== 1'b1 || full0 !== 1'b0 || q0 !== 8'h30)
            $display("FAIL full_rdwr got usedw=%0d ovf=%b full=%b q=%h exp 7 1 0 30", usedw0, ovf0, full0, q0);
        else pass_cnt++;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00);
            total_cnt++;
            if (q0 !== 8'(8'h31 + i)) $display("FAIL full_rdwr_drain[%0d] got q=%h exp %h", i, q0, 8'(8'h31 + i));
            else pass_cnt++;
        end
        total_cnt++;
        if (empty0 !== 1'b1 || usedw0 !== 4'd0) $display("FAIL full_rdwr_empty got empty=%b usedw=%0d exp 1 0", empty0, usedw0);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_fwft();
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        total_cnt++;
        if (empty1 !== 1'b0 || q1 !== 8'hA5 || usedw1 !== 4'd1) $display("FAIL fwft_write got empty=%b q=%h usedw=%0d exp 0 a5 1", empty1, q1, usedw1);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total_cnt++;
        if (q1 !== 8'hA5 || empty1 !== 1'b0 || q0 !== 8'h00) $display("FAIL fwft_hold got q1=%h empty=%b q0=%h exp a5 0 00", q1, empty1, q0);
        else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++;
        if (empty1 !== 1'b1 || usedw1 !== 4'd0 || q1 !== 8'hA5) $display("FAIL fwft_pop got empty=%b usedw=%0d q=%h exp 1 0 a5", empty1, usedw1, q1);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 8'hC3);
        step(1'b1, 1'b1, 1'b0, 8'hD4);
        total_cnt++;
        if (usedw1 !== 4'd1 || q1 !== 8'hD4 || q0 !== 8'hC3) $display("FAIL fwft_bypass got usedw=%0d q1=%h q0=%h exp 1 d4 c3", usedw1, q1, q0);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_clr();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++;
        if (udf0 !== 1'b1) $display("FAIL clr_underflow_set got %b exp 1", udf0);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h45);
        total_cnt++;
        if (usedw0 !== 4'd5 || q0 !== 8'h40) $display("FAIL clr_pre got usedw=%0d q=%h exp 5 40", usedw0, q0);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b1, 8'h99);
        total_cnt++;
        if (usedw0 !== 4'd0 || empty0 !== 1'b1 || udf0 !== 1'b0 || q0 !== 8'h00 || ae0 !== 1'b1)
            $display("FAIL clr_apply got usedw=%0d empty=%b udf=%b q=%h ae=%b exp 0 1 0 00 1", usedw0, empty0, udf0, q0, ae0);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total_cnt++;
        if (usedw0 !== 4'd0 || usedw1 !== 4'd0) $display("FAIL clr_wr_dropped got usedw0=%0d usedw1=%0d exp 0 0", usedw0, usedw1);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++;
        if (q0 !== 8'h50 || usedw0 !== 4'd2) $display("FAIL rstmid_pre got q=%h usedw=%0d exp 50 2", q0, usedw0);
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (usedw0 !== 4'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || q0 !== 8'h00 || q1 !== 8'h00 || {ovf0, udf0, af0, ae0} !== 4'b0001)
            $display("FAIL rstmid_async got usedw=%0d empty=%b full=%b q0=%h q1=%h flags=%b exp 0 1 0 00 00 0001", usedw0, empty0, full0, q0, q1, {ovf0, udf0, af0, ae0});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h61);
        total_cnt++;
        if (q1 !== 8'h61 || usedw0 !== 4'd1) $display("FAIL rstmid_first_write got q1=%h usedw=%0d exp 61 1", q1, usedw0);
        else pass_cnt++;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total_cnt++;
        if (q0 !== 8'h61 || empty0 !== 1'b1) $display("FAIL rstmid_read got q0=%h empty=%b exp 61 1", q0, empty0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_full_rdwr();
        test_fwft();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
